serial_adder_tree_sequencer: RTL and testbench
==============================================

# serial_adder_tree_sequencer

Sums a block of N = 2^LOG2N signed samples by time-multiplexing one registered two-input adder stage through a pairwise reduction tree. It sits downstream of sample producers in the linear-algebra datapath, where a full parallel adder tree is too costly. It loads samples serially into a local buffer, sequences the tree levels on the shared adder, and emits one full-precision sum per block with a single-cycle ready strobe.

## Interface
- IN_WIDTH, 10, input sample width (signed two's complement)
- LOG2N, 3, log2 of block length N; legal range 1..6
- OUT_WIDTH (localparam), IN_WIDTH+LOG2N, buffer, adder and result width
- clk  input  1  rising-edge clock; one clock domain
- reset  input  1  synchronous, active-high
- enable  input  1  global clock-enable; when low, all state and outputs hold
- inReady  input  1  sample valid strobe
- in  input  IN_WIDTH  signed sample
- busy  output  1  high while reducing; samples presented while busy are dropped
- outReady  output  1  one-cycle strobe marking `out` valid
- out  output  OUT_WIDTH  signed block sum

## Operation
- States: LOAD, REDUCE. Reset enters LOAD, with wr_idx=0, level=0, pair=0, busy=0, outReady=0. `out` and the buffer are not reset.
- All register updates except reset happen only on edges where enable=1. With enable=0 nothing changes, including outReady, which holds its level.
- LOAD:
  - On an enabled edge with inReady=1, write sign-extend(in) to buf[wr_idx] and increment wr_idx.
  - When the N-th sample is written, clear wr_idx, set busy=1 and enter REDUCE at level 0, pair 0.
- REDUCE, level l:
  - The level has P = N>>(l+1) issue cycles plus 1 drain cycle.
  - Issue cycle j (0..P-1): the adder register loads buf[2j]+buf[2j+1]. The previous issue's result is written to buf[j-1].
  - Drain cycle: the last result is written to buf[P-1]; no new issue.
  - The drain cycle is mandatory. It prevents a read-before-write hazard on buf[1] at the start of the next level.
  - After the drain of level l < LOG2N-1, go to level l+1, pair 0.
- Final drain (level LOG2N-1):
  - out <= adder register, outReady <= 1, busy <= 0, state -> LOAD.
  - outReady clears on the next enabled edge.
- inReady=1 during REDUCE is ignored. No sample is captured or counted.
- Arithmetic:
  - All operands are sign-extended to OUT_WIDTH.
  - Sums are exact with no overflow; the magnitude is bounded by N·2^(IN_WIDTH-1).
  - No saturation and no rounding.
- Reset asserted mid-load or mid-reduce discards the partial block. outReady=0 on the following cycle.
- The next sample can be accepted on the enabled edge right after the edge that sets outReady. On that edge outReady falls and busy is already 0.

## Timing
- Let edge E be the enabled edge that accepts the N-th sample. Count only enabled edges.
- busy is high from E+1 through E+N-1+LOG2N. outReady is high after edge E+N-1+LOG2N.
- Latency, last sample to outReady: N-1+LOG2N enabled edges; 10 for the default N=8.
- Sustained throughput: one block per 2N-1+LOG2N enabled cycles.
- Adder stage latency is 1 cycle. Buffer writes occur one edge after their issue.
- enable low for k cycles during REDUCE extends the latency by exactly k.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Defaults, samples 1..8 on consecutive cycles: busy for 10 cycles, then out=36 with outReady high for exactly 1 cycle.
- Extremes:
  - Eight samples of -512: out=-4096.
  - Eight samples of +511: out=4088.
  - Alternating ±511: out=0.
- Drops during REDUCE: hold inReady=1 with values 100.. through REDUCE. Samples during busy are dropped, and the next block sums only the 8 samples accepted after busy falls.
- Stall: pull enable low for 5 cycles mid-REDUCE. outReady arrives 15 edges after the last sample with the same sum, and outReady stays high across an enable-low window.
- Reset: assert reset at the 3rd reduce cycle. No outReady appears; the next block of 8 samples with value 2 gives out=16.
- Minimum size, LOG2N=1, samples 3 and -5: out=-2 with outReady 2 edges after the second sample.

Source files
------------

// File: rtl/serial_adder_tree_sequencer_if.sv
// Sample/result bus for serial_adder_tree_sequencer.
//   enable   : global clock-enable from the producer side
//   inReady  : sample valid strobe
//   in       : signed input sample (IN_WIDTH)
//   busy     : high while the block is being reduced; samples are dropped
//   outReady : one-cycle strobe marking out valid
//   out      : signed full-precision block sum (IN_WIDTH+LOG2N)
// master = sample producer / result consumer, slave = the sequencer.
interface serial_adder_tree_sequencer_if #(
    parameter int IN_WIDTH = 10,
    parameter int LOG2N    = 3
);
    localparam int OUT_WIDTH = IN_WIDTH + LOG2N;

    logic                        enable;
    logic                        inReady;
    logic signed [IN_WIDTH-1:0]  in;
    logic                        busy;
    logic                        outReady;
    logic signed [OUT_WIDTH-1:0] out;

    modport master (
        output enable, inReady, in,
        input  busy, outReady, out
    );

    modport slave (
        input  enable, inReady, in,
        output busy, outReady, out
    );
endinterface

// File: rtl/serial_adder_tree_sequencer.sv
// serial_adder_tree_sequencer
// Sums blocks of N = 2^LOG2N signed samples using a single registered
// two-input adder that is time-multiplexed over a pairwise reduction tree.
// Samples are written serially into a local buffer; each tree level then
// issues N>>(level+1) pair additions followed by one drain cycle that
// writes back the last partial sum before the next level reads it.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-high; clears control state only
//   bus    : slave side of serial_adder_tree_sequencer_if
//            (enable, inReady, in -> busy, outReady, out)
module serial_adder_tree_sequencer #(
    parameter int IN_WIDTH = 10,
    parameter int LOG2N    = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    serial_adder_tree_sequencer_if.slave  bus
);
    localparam int OUT_WIDTH = IN_WIDTH + LOG2N;
    localparam int N         = 1 << LOG2N;

    typedef enum logic {LOAD, REDUCE} state_t;

    state_t                      state;
    logic [LOG2N-1:0]            wr_idx;
    logic [2:0]                  level;
    logic [LOG2N-1:0]            pair;
    logic                        busy_q;
    logic                        out_rdy_q;

    logic signed [OUT_WIDTH-1:0] sbuf [N];
    logic signed [OUT_WIDTH-1:0] sum_p1;
    logic signed [OUT_WIDTH-1:0] res_p2;

    logic [LOG2N-1:0]            pairs_lvl;
    logic [LOG2N-1:0]            rd_a;
    logic [LOG2N-1:0]            rd_b;
    logic                        ld_wr;
    logic                        issue;
    logic                        wb_en;
    logic                        last_fin;

    function automatic logic signed [OUT_WIDTH-1:0] sext(input logic signed [IN_WIDTH-1:0] x);
        return OUT_WIDTH'(x);
    endfunction

    function automatic logic signed [OUT_WIDTH-1:0] add_exact(input logic signed [OUT_WIDTH-1:0] a,
                                                              input logic signed [OUT_WIDTH-1:0] b);
        // OUT_WIDTH carries LOG2N guard bits, so the full tree can never overflow.
        return a + b;
    endfunction

    always_comb begin
        pairs_lvl = LOG2N'(N >> (level + 3'd1));
        rd_a      = pair << 1;
        rd_b      = rd_a | LOG2N'(1);
        ld_wr     = (state == LOAD) && bus.inReady;
        issue     = (state == REDUCE) && (pair != pairs_lvl);
        // Every REDUCE cycle after the first of a level retires the previous
        // issue into buf[pair-1]; on the drain cycle pair == P, so this is buf[P-1].
        wb_en     = (state == REDUCE) && (pair != '0);
        last_fin  = (state == REDUCE) && (pair == pairs_lvl) && (level == 3'(LOG2N - 1));
    end

    // Control: sequencing state, the only registers touched by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= LOAD;
            wr_idx    <= '0;
            level     <= '0;
            pair      <= '0;
            busy_q    <= 1'b0;
            out_rdy_q <= 1'b0;
        end else if (bus.enable) begin
            out_rdy_q <= 1'b0;
            case (state)
                LOAD: begin
                    if (bus.inReady) begin
                        if (wr_idx == LOG2N'(N - 1)) begin
                            wr_idx <= '0;
                            busy_q <= 1'b1;
                            level  <= '0;
                            pair   <= '0;
                            state  <= REDUCE;
                        end else begin
                            wr_idx <= wr_idx + 1'b1;
                        end
                    end
                end
                REDUCE: begin
                    if (issue) begin
                        pair <= pair + 1'b1;
                    end else if (last_fin) begin
                        out_rdy_q <= 1'b1;
                        busy_q    <= 1'b0;
                        level     <= '0;
                        pair      <= '0;
                        state     <= LOAD;
                    end else begin
                        level <= level + 3'd1;
                        pair  <= '0;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    // Stage p0 -> p1: buffer read, shared adder register; writeback one edge later.
    // Stage p1 -> p2: final adder value captured as the block result.
    always_ff @(posedge clk) begin
        if (bus.enable) begin
            if (ld_wr) begin
                sbuf[wr_idx] <= sext(bus.in);
            end
            if (wb_en) begin
                sbuf[pair - 1'b1] <= sum_p1;
            end
            if (issue) begin
                sum_p1 <= add_exact(sbuf[rd_a], sbuf[rd_b]);
            end
            if (last_fin) begin
                res_p2 <= sum_p1;
            end
        end
    end

    assign bus.busy     = busy_q;
    assign bus.outReady = out_rdy_q;
    assign bus.out      = res_p2;
endmodule

// File: tb/tb_serial_adder_tree_sequencer.sv
module tb_serial_adder_tree_sequencer;
    localparam int IW = 10;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    serial_adder_tree_sequencer_if #(.IN_WIDTH(IW), .LOG2N(3)) bus0 ();
    serial_adder_tree_sequencer_if #(.IN_WIDTH(IW), .LOG2N(1)) bus1 ();

    serial_adder_tree_sequencer #(.IN_WIDTH(IW), .LOG2N(3)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    serial_adder_tree_sequencer #(.IN_WIDTH(IW), .LOG2N(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual %0d required %0d", nm, act, exp);
    endtask

    // Reference model for dut0 (N=8): a block is 8 accepted samples whose
    // plain sum appears N-1+LOG2N = 10 enabled edges after the 8th one.
    int     m_cnt  = 0;
    longint m_acc  = 0;
    longint m_pend = 0;
    longint m_out  = 0;
    int     m_busy = 0;
    bit     m_rdy  = 0;
    int     m_done = 0;
    bit     chk_on = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_cnt  = 0;
            m_acc  = 0;
            m_busy = 0;
            m_rdy  = 0;
        end else if (bus0.enable) begin
            m_rdy = 0;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_rdy  = 1;
                    m_out  = m_pend;
                    m_done++;
                end
            end else if (bus0.inReady) begin
                m_acc += longint'(bus0.in);
                m_cnt++;
                if (m_cnt == 8) begin
                    m_pend = m_acc;
                    m_acc  = 0;
                    m_cnt  = 0;
                    m_busy = 10;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("sb_busy", longint'(bus0.busy), longint'(m_busy > 0));
            check("sb_outReady", longint'(bus0.outReady), longint'(m_rdy));
            if (m_rdy) check("sb_out", longint'(bus0.out), m_out);
        end
    end

    typedef struct packed {
        logic [8*IW-1:0]   s;
        logic signed [15:0] exp;
    } vec_t;

    vec_t vecs [4];

    // Called at a negedge; returns at the negedge after the 8th accepting edge.
    task automatic load8(input logic [8*IW-1:0] s);
        for (int i = 0; i < 8; i++) begin
            bus0.inReady = 1'b1;
            bus0.in      = s[i*IW +: IW];
            @(negedge clk);
        end
        bus0.inReady = 1'b0;
    endtask

    task automatic run_block(input logic [8*IW-1:0] s, input int stall_at, input int stall_len,
                             input bit drop, output longint sum, output int lat,
                             output int bcnt, output bit got);
        load8(s);
        lat  = 0;
        bcnt = 0;
        got  = 0;
        sum  = 0;
        for (int k = 0; k < 60 && !got; k++) begin
            if (k == stall_at) bus0.enable = 1'b0;
            if (k == stall_at + stall_len) bus0.enable = 1'b1;
            if (bus0.busy) bcnt++;
            if (drop) begin
                bus0.inReady = 1'b1;
                bus0.in      = IW'(100 + k);
            end
            @(negedge clk);
            lat++;
            if (bus0.outReady) begin
                got = 1;
                sum = longint'(bus0.out);
            end
        end
        bus0.inReady = 1'b0;
        bus0.enable  = 1'b1;
    endtask

    function automatic longint sum8(input logic [8*IW-1:0] s);
        longint t = 0;
        for (int i = 0; i < 8; i++) begin
            logic signed [IW-1:0] x;
            x = s[i*IW +: IW];
            t += longint'(x);
        end
        return t;
    endfunction

    initial begin
        longint         sum;
        int             lat;
        int             bcnt;
        bit             got;
        logic [8*IW-1:0] rs;
        int             nrdy;
        int             d0;

        for (int i = 0; i < 8; i++) begin
            vecs[0].s[i*IW +: IW] = IW'(i + 1);
            vecs[1].s[i*IW +: IW] = IW'(-512);
            vecs[2].s[i*IW +: IW] = IW'(511);
            vecs[3].s[i*IW +: IW] = (i % 2 == 0) ? IW'(511) : IW'(-511);
        end
        vecs[0].exp = 16'sd36;
        vecs[1].exp = -16'sd4096;
        vecs[2].exp = 16'sd4088;
        vecs[3].exp = 16'sd0;

        reset        = 1'b1;
        bus0.enable  = 1'b1;
        bus0.inReady = 1'b0;
        bus0.in      = '0;
        bus1.enable  = 1'b1;
        bus1.inReady = 1'b0;
        bus1.in      = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", longint'(bus0.busy), 0);
        check("rst_outReady", longint'(bus0.outReady), 0);
        check("rst_busy_n2", longint'(bus1.busy), 0);
        check("rst_outReady_n2", longint'(bus1.outReady), 0);
        reset  = 1'b0;
        chk_on = 1'b1;

        // Table-driven blocks on consecutive cycles
        for (int v = 0; v < 4; v++) begin
            run_block(vecs[v].s, -1, 0, 1'b0, sum, lat, bcnt, got);
            check($sformatf("vec%0d_got", v), longint'(got), 1);
            check($sformatf("vec%0d_sum", v), sum, longint'($signed(vecs[v].exp)));
            check($sformatf("vec%0d_latency", v), longint'(lat), 10);
            check($sformatf("vec%0d_busy_cycles", v), longint'(bcnt), 10);
            @(negedge clk);
            check($sformatf("vec%0d_strobe_1cyc", v), longint'(bus0.outReady), 0);
        end

        // Samples presented while busy are dropped
        for (int i = 0; i < 8; i++) rs[i*IW +: IW] = IW'($urandom_range(0, 1023));
        run_block(rs, -1, 0, 1'b1, sum, lat, bcnt, got);
        check("drop_blkA_sum", sum, sum8(rs));
        check("drop_blkA_latency", longint'(lat), 10);
        for (int i = 0; i < 8; i++) rs[i*IW +: IW] = IW'(300 + i);
        run_block(rs, -1, 0, 1'b0, sum, lat, bcnt, got);
        check("drop_blkB_sum", sum, 2428);
        @(negedge clk);

        // Stall of 5 enable-low cycles mid-reduce, then hold outReady across a stall
        for (int i = 0; i < 8; i++) rs[i*IW +: IW] = IW'($urandom_range(0, 1023));
        run_block(rs, 3, 5, 1'b0, sum, lat, bcnt, got);
        check("stall_sum", sum, sum8(rs));
        check("stall_latency", longint'(lat), 15);
        check("stall_busy_cycles", longint'(bcnt), 15);
        bus0.enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_outReady_hold", longint'(bus0.outReady), 1);
        end
        bus0.enable = 1'b1;
        @(negedge clk);
        check("stall_outReady_clear", longint'(bus0.outReady), 0);

        // Reset on the 3rd reduce cycle discards the block
        for (int i = 0; i < 8; i++) rs[i*IW +: IW] = IW'($urandom_range(0, 1023));
        load8(rs);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy", longint'(bus0.busy), 0);
        nrdy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus0.outReady) nrdy++;
        end
        check("midrst_no_outReady", longint'(nrdy), 0);
        for (int i = 0; i < 8; i++) rs[i*IW +: IW] = IW'(2);
        run_block(rs, -1, 0, 1'b0, sum, lat, bcnt, got);
        check("midrst_next_sum", sum, 16);
        check("midrst_next_latency", longint'(lat), 10);
        @(negedge clk);

        // Minimum size N=2
        bus1.inReady = 1'b1;
        bus1.in      = IW'(3);
        @(negedge clk);
        bus1.in      = IW'(-5);
        @(negedge clk);
        bus1.inReady = 1'b0;
        check("n2_busy", longint'(bus1.busy), 1);
        @(negedge clk);
        check("n2_outReady_early", longint'(bus1.outReady), 0);
        @(negedge clk);
        check("n2_outReady", longint'(bus1.outReady), 1);
        check("n2_sum", longint'(bus1.out), -2);
        check("n2_busy_after", longint'(bus1.busy), 0);
        @(negedge clk);
        check("n2_strobe_1cyc", longint'(bus1.outReady), 0);

        // Randomized traffic against the reference model
        d0 = m_done;
        for (int c = 0; c < 800; c++) begin
            reset        = ($urandom_range(0, 299) == 0);
            bus0.enable  = ($urandom_range(0, 5) != 0);
            bus0.inReady = ($urandom_range(0, 2) != 0);
            bus0.in      = IW'($urandom_range(0, 1023));
            @(negedge clk);
        end
        reset        = 1'b0;
        bus0.enable  = 1'b1;
        bus0.inReady = 1'b0;
        repeat (20) @(negedge clk);
        check("rand_blocks_done", longint'((m_done - d0) >= 5), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
